// File: rtl/mem_lsu_if.sv
// Datapath request/response and data-memory bus bundle for the load/store unit.
// The slave modport is the LSU's view; master is the datapath-plus-memory side.
interface mem_lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid_i;
  logic [XLEN-1:0] req_addr_i;
  logic [1:0]      req_size_i;
  logic            req_wr_i;
  logic            req_zero_extnd_i;
  logic [XLEN-1:0] req_wr_data_i;
  logic            req_ready_o;

  logic            resp_valid_o;
  logic [XLEN-1:0] resp_rd_data_o;

  logic            dmem_ready_i;
  logic            dmem_req_o;
  logic            dmem_wr_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wr_data_o;
  logic [XLEN/8-1:0] dmem_mask_o;
  logic            dmem_resp_valid_i;
  logic [XLEN-1:0] dmem_rd_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_size_i, req_wr_i, req_zero_extnd_i, req_wr_data_i,
    output req_ready_o, resp_valid_o, resp_rd_data_o,
    input  dmem_ready_i, dmem_resp_valid_i, dmem_rd_data_i,
    output dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_wr_data_o, dmem_mask_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_size_i, req_wr_i, req_zero_extnd_i, req_wr_data_i,
    input  req_ready_o, resp_valid_o, resp_rd_data_o,
    output dmem_ready_i, dmem_resp_valid_i, dmem_rd_data_i,
    input  dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_wr_data_o, dmem_mask_o
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: screens requests for misalignment and the inaccessible window, issues
// them to data memory, and tracks them in order so load responses can be aligned/extended.
module mem_lsu #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] OOB_BASE  = 'h1_0000,
  parameter logic [XLEN-1:0] OOB_LIMIT = 'h1_BFFF
) (
  input  logic                         clk,
  input  logic                         resetn,
  mem_lsu_if.slave                     bus,
  input  logic                         flush_i,
  input  logic                         exc_valid_i,
  input  logic [4:0]                   exc_code_i,
  output logic                         exc_valid_o,
  output logic [4:0]                   exc_code_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [OW-1:0] off;
    logic [1:0]    size;
    logic          zext;
    logic          wr;
    logic          killed;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [PW-1:0] count;

  logic          ready;
  logic          qual;
  logic          oob;
  logic          mis_raw;
  logic          mis;
  logic          hs;
  logic          pop;
  logic [OW-1:0] off;
  logic [4:0]    local_code;
  logic [XLEN-1:0] st_mask;
  logic [NB-1:0]   st_lanes;
  logic [XLEN-1:0] st_data;
  entry_t          head_e;
  entry_t          new_e;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_mask;
  logic            ld_sign;
  logic [XLEN-1:0] ld_data;
  logic            resp_ok;

  // A slot freed by a response this cycle only becomes usable next cycle.
  assign ready           = bus.dmem_ready_i & (count < PW'(DEPTH));
  assign bus.req_ready_o = ready;
  assign off             = bus.req_addr_i[OW-1:0];
  assign qual            = resetn & bus.req_valid_i & ready & ~flush_i;
  assign oob             = qual & (bus.req_addr_i >= OOB_BASE) & (bus.req_addr_i <= OOB_LIMIT);
  assign mis             = qual & mis_raw;
  assign hs              = qual & ~exc_valid_i & ~oob & ~mis;

  always_comb begin
    case (bus.req_size_i)
      2'd0:    mis_raw = 1'b0;
      2'd1:    mis_raw = bus.req_addr_i[0];
      2'd2:    mis_raw = |bus.req_addr_i[1:0];
      default: mis_raw = (XLEN == 32) | (|bus.req_addr_i[2:0]);
    endcase
  end

  assign local_code  = oob ? (bus.req_wr_i ? 5'd7 : 5'd5) : (bus.req_wr_i ? 5'd6 : 5'd4);
  assign exc_valid_o = resetn & (exc_valid_i | oob | mis);
  assign exc_code_o  = !resetn     ? 5'd0 :
                       exc_valid_i ? exc_code_i :
                       (oob | mis) ? local_code : 5'd0;

  always_comb begin
    st_mask  = '1;
    st_lanes = NB'(8'hFF);
    case (bus.req_size_i)
      2'd0: begin st_mask = XLEN'(8'hFF);         st_lanes = NB'(4'h1); end
      2'd1: begin st_mask = XLEN'(16'hFFFF);      st_lanes = NB'(4'h3); end
      2'd2: begin st_mask = XLEN'(32'hFFFF_FFFF); st_lanes = NB'(4'hF); end
      default: ;
    endcase
    st_data = (bus.req_wr_data_i & st_mask) << {off, 3'b000};
  end

  assign bus.dmem_req_o     = hs;
  assign bus.dmem_wr_o      = hs & bus.req_wr_i;
  assign bus.dmem_addr_o    = hs ? bus.req_addr_i : '0;
  assign bus.dmem_wr_data_o = (hs & bus.req_wr_i) ? st_data : '0;
  assign bus.dmem_mask_o    = (hs & bus.req_wr_i) ? (st_lanes << off) : '0;

  assign head_e  = q_mem[head];
  assign pop     = bus.dmem_resp_valid_i & (count != '0);
  assign resp_ok = resetn & pop & ~head_e.wr & ~head_e.killed & ~flush_i & ~exc_valid_i;

  // Shift the addressed bytes down to bit 0, then fill the upper bits by sign or zero.
  always_comb begin
    shifted = bus.dmem_rd_data_i >> {head_e.off, 3'b000};
    ld_mask = '1;
    ld_sign = 1'b0;
    case (head_e.size)
      2'd0: begin ld_mask = XLEN'(8'hFF);         ld_sign = shifted[7];  end
      2'd1: begin ld_mask = XLEN'(16'hFFFF);      ld_sign = shifted[15]; end
      2'd2: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = shifted[31]; end
      default: ;
    endcase
    ld_data = (shifted & ld_mask) | ((ld_sign & ~head_e.zext) ? ~ld_mask : '0);
  end

  assign bus.resp_valid_o   = resp_ok;
  assign bus.resp_rd_data_o = resp_ok ? ld_data : '0;
  assign pending_o          = count;

  always_comb begin
    new_e.off    = off;
    new_e.size   = bus.req_size_i;
    new_e.zext   = bus.req_zero_extnd_i;
    new_e.wr     = bus.req_wr_i;
    new_e.killed = 1'b0;
  end

  // Flush marks every slot killed; stale slots are overwritten with killed=0 when reused,
  // and a flush cycle never pushes, so the two updates cannot collide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) q_mem[i].killed <= 1'b1;
      end
      if (hs) begin
        q_mem[tail] <= new_e;
        tail        <= (tail == AW'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == AW'(DEPTH - 1)) ? '0 : head + 1'b1;
      end
      count <= count + PW'(hs) - PW'(pop);
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random traffic, checked
// against a byte-level model holding outstanding requests in a queue.
module tb_mem_lsu;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam logic [63:0] OOB_BASE  = 64'h1_0000;
  localparam logic [63:0] OOB_LIMIT = 64'h1_BFFF;

  typedef struct {
    int off;
    int size;
    bit zext;
    bit wr;
    bit killed;
  } ent_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush_i;
  logic       exc_valid_i;
  logic [4:0] exc_code_i;
  logic       exc_valid_o;
  logic [4:0] exc_code_o;
  logic [2:0] pending_o;

  int total = 0;
  int bad = 0;
  ent_t mq[$];

  mem_lsu_if #(.XLEN(XLEN)) bus ();

  mem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .OOB_BASE(OOB_BASE), .OOB_LIMIT(OOB_LIMIT)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .flush_i(flush_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [1:0] sz,
                               input logic w, input logic z, input logic [63:0] wd,
                               input logic dr, input logic rv, input logic [63:0] rd,
                               input logic fl, input logic ev, input logic [4:0] ec);
    bus.req_valid_i       = v;
    bus.req_addr_i        = a;
    bus.req_size_i        = sz;
    bus.req_wr_i          = w;
    bus.req_zero_extnd_i  = z;
    bus.req_wr_data_i     = wd;
    bus.dmem_ready_i      = dr;
    bus.dmem_resp_valid_i = rv;
    bus.dmem_rd_data_i    = rd;
    flush_i               = fl;
    exc_valid_i           = ev;
    exc_code_i            = ec;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [63:0] a, input logic [1:0] sz, input logic z);
    applyStimulus(1, a, sz, 0, z, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic resp(input logic [63:0] rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, rd, 0, 0, 0);
  endtask

  // Compares every output with the model for the current inputs, then clocks the model.
  task automatic checkOutput(input string tag);
    int np, off, n;
    bit rdy, qq, oob, mis, ev, hs, has, rv;
    logic [4:0] code;
    logic [63:0] a, wd, ld;
    logic [7:0] mk;
    ent_t h, e;
    np = mq.size();
    if (!resetn) begin
      mq.delete();
      compare({tag, ".ready"}, 64'(bus.req_ready_o), 64'(bus.dmem_ready_i));
      compare({tag, ".resp_valid"}, 64'(bus.resp_valid_o), 0);
      compare({tag, ".resp_data"}, bus.resp_rd_data_o, 0);
      compare({tag, ".dmem_req"}, 64'(bus.dmem_req_o), 0);
      compare({tag, ".dmem_wr"}, 64'(bus.dmem_wr_o), 0);
      compare({tag, ".dmem_addr"}, bus.dmem_addr_o, 0);
      compare({tag, ".dmem_wdata"}, bus.dmem_wr_data_o, 0);
      compare({tag, ".dmem_mask"}, 64'(bus.dmem_mask_o), 0);
      compare({tag, ".exc_valid"}, 64'(exc_valid_o), 0);
      compare({tag, ".exc_code"}, 64'(exc_code_o), 0);
      compare({tag, ".pending"}, 64'(pending_o), 0);
      @(posedge clk);
      #1;
      return;
    end
    a   = bus.req_addr_i;
    off = int'(a[2:0]);
    n   = 1 << bus.req_size_i;
    rdy = bus.dmem_ready_i && (np < DEPTH);
    qq  = bus.req_valid_i && rdy && !flush_i;
    oob = qq && (a >= OOB_BASE) && (a <= OOB_LIMIT);
    mis = qq && ((a % 64'(n)) != 0);
    ev  = exc_valid_i || oob || mis;
    code = exc_valid_i ? exc_code_i : oob ? (bus.req_wr_i ? 5'd7 : 5'd5)
                                    : mis ? (bus.req_wr_i ? 5'd6 : 5'd4) : 5'd0;
    hs  = qq && !ev;
    wd  = 0;
    mk  = 0;
    if (hs && bus.req_wr_i) begin
      for (int b = 0; b < n; b++) begin
        if (off + b < 8) begin
          wd[8*(off+b) +: 8] = bus.req_wr_data_i[8*b +: 8];
          mk[off+b] = 1'b1;
        end
      end
    end
    compare({tag, ".ready"}, 64'(bus.req_ready_o), 64'(rdy));
    compare({tag, ".dmem_req"}, 64'(bus.dmem_req_o), 64'(hs));
    compare({tag, ".dmem_wr"}, 64'(bus.dmem_wr_o), 64'(hs && bus.req_wr_i));
    compare({tag, ".dmem_addr"}, bus.dmem_addr_o, hs ? a : 64'd0);
    compare({tag, ".dmem_wdata"}, bus.dmem_wr_data_o, wd);
    compare({tag, ".dmem_mask"}, 64'(bus.dmem_mask_o), 64'(mk));
    compare({tag, ".exc_valid"}, 64'(exc_valid_o), 64'(ev));
    compare({tag, ".exc_code"}, 64'(exc_code_o), 64'(code));
    compare({tag, ".pending"}, 64'(pending_o), 64'(np));
    has = bus.dmem_resp_valid_i && (np > 0);
    h = '{0, 0, 0, 0, 0};
    if (has) h = mq[0];
    rv = has && !h.wr && !h.killed && !flush_i && !exc_valid_i;
    compare({tag, ".resp_valid"}, 64'(bus.resp_valid_o), 64'(rv));
    if (rv) begin
      ld = 0;
      for (int b = 0; b < (1 << h.size); b++) ld[8*b +: 8] = bus.dmem_rd_data_i[8*(h.off+b) +: 8];
      if (!h.zext && ld[8*(1 << h.size)-1]) begin
        for (int b = (1 << h.size); b < 8; b++) ld[8*b +: 8] = 8'hFF;
      end
      compare({tag, ".resp_data"}, bus.resp_rd_data_o, ld);
    end
    e = '{off, int'(bus.req_size_i), bus.req_zero_extnd_i, bus.req_wr_i, 1'b0};
    @(posedge clk);
    if (flush_i) foreach (mq[i]) mq[i].killed = 1'b1;
    if (has) void'(mq.pop_front());
    if (hs) mq.push_back(e);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    checkOutput("reset");
    applyStimulus(1, 64'h2000, 2, 1, 0, 64'h1234, 0, 1, 64'hFF, 1, 1, 5'd9);
    checkOutput("reset_busy");
    resetn = 1'b1;

    load(64'h1003, 0, 0);
    compare("lb.mask", 64'(bus.dmem_mask_o), 0);
    checkOutput("lb_issue");
    resp(64'h0000_0000_80FF_0000);
    compare("lb.data", bus.resp_rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_resp");
    load(64'h1003, 0, 1);
    checkOutput("lbu_issue");
    resp(64'h0000_0000_80FF_0000);
    compare("lbu.data", bus.resp_rd_data_o, 64'h80);
    checkOutput("lbu_resp");

    applyStimulus(1, 64'h2006, 1, 1, 0, 64'hBEEF, 1, 0, 0, 0, 0, 0);
    compare("sh.wdata", bus.dmem_wr_data_o, 64'hBEEF_0000_0000_0000);
    compare("sh.mask", 64'(bus.dmem_mask_o), 64'hC0);
    checkOutput("sh");
    resp(64'hDEAD);
    compare("sh.resp_silent", 64'(bus.resp_valid_o), 0);
    checkOutput("sh_resp");

    load(64'h1_0004, 2, 0);
    compare("lw_oob.code", 64'(exc_code_o), 5);
    compare("lw_oob.req", 64'(bus.dmem_req_o), 0);
    checkOutput("lw_oob");
    applyStimulus(1, 64'h2004, 3, 1, 0, 64'h55, 1, 0, 0, 0, 0, 0);
    compare("sd_mis.code", 64'(exc_code_o), 6);
    checkOutput("sd_mis");
    applyStimulus(1, 64'h1_BFFF, 0, 1, 0, 64'h1, 1, 0, 0, 0, 0, 0);
    checkOutput("sb_limit");
    load(64'h1_0001, 1, 0);
    checkOutput("lh_oob_and_mis");
    load(64'h1_C000, 0, 0);
    checkOutput("lb_above_limit");
    load(64'hFFFF, 0, 0);
    checkOutput("lb_below_base");
    applyStimulus(1, 64'h1_0000, 2, 0, 0, 0, 1, 0, 0, 0, 1, 5'd3);
    checkOutput("upstream_exc");
    resp(64'h1122_3344_5566_7788);
    checkOutput("resp_above");
    resp(64'h1122_3344_5566_7788);
    checkOutput("resp_below");

    for (int i = 0; i < 4; i++) begin
      load(64'h3000 + 64'(8*i), 3, 0);
      checkOutput("fill");
    end
    load(64'h3020, 3, 0);
    compare("full.pending", 64'(pending_o), 4);
    compare("full.ready", 64'(bus.req_ready_o), 0);
    checkOutput("full_blocked");
    applyStimulus(1, 64'h3020, 3, 0, 0, 0, 1, 1, 64'hA5A5_0000_1111_2222, 0, 0, 0);
    compare("full_pop.ready", 64'(bus.req_ready_o), 0);
    checkOutput("full_pop");
    idle();
    compare("after_pop.pending", 64'(pending_o), 3);
    compare("after_pop.ready", 64'(bus.req_ready_o), 1);
    checkOutput("after_pop");
    applyStimulus(1, 64'h3028, 2, 0, 1, 0, 1, 1, 64'h8000_0000_8000_0000, 0, 0, 0);
    checkOutput("push_pop");
    for (int i = 0; i < 3; i++) begin
      resp(64'hF0E1_D2C3_B4A5_9687 + 64'(i));
      checkOutput("drain");
    end

    load(64'h4002, 1, 0);
    checkOutput("fl_ld1");
    load(64'h4004, 2, 0);
    checkOutput("fl_ld2");
    applyStimulus(1, 64'h4008, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    checkOutput("flush");
    load(64'h400C, 2, 0);
    checkOutput("fl_ld3");
    resp(64'h0000_0000_8001_0000);
    compare("killed1", 64'(bus.resp_valid_o), 0);
    checkOutput("fl_r1");
    resp(64'h1234_5678_9ABC_DEF0);
    compare("killed2", 64'(bus.resp_valid_o), 0);
    checkOutput("fl_r2");
    resp(64'h8765_4321_0000_0000);
    compare("live3", 64'(bus.resp_valid_o), 1);
    checkOutput("fl_r3");

    for (int i = 0; i < 3; i++) begin
      load(64'h5000 + 64'(4*i), 2, 0);
      checkOutput("pre_rst");
    end
    resetn = 1'b0;
    #1;
    compare("rst_mid.pending", 64'(pending_o), 0);
    idle();
    checkOutput("rst_mid");
    resetn = 1'b1;
    resp(64'hFFFF_FFFF_FFFF_FFFF);
    compare("stray.resp", 64'(bus.resp_valid_o), 0);
    checkOutput("stray");
    idle();
    compare("stray.pending", 64'(pending_o), 0);
    checkOutput("stray_after");

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 3))
        0: a = OOB_BASE + 64'($urandom_range(0, 'hC003));
        1: a = 64'hFFF8 + 64'($urandom_range(0, 15));
        2: a = {32'd0, $urandom};
        default: a = 64'h2000 + 64'($urandom_range(0, 63));
      endcase
      applyStimulus($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, {$urandom, $urandom},
                    $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                    5'($urandom_range(0, 31)));
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath and address width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding data-memory requests (2..16).
REQ-003 SHALL have parameter OOB_BASE, default 'h1_0000, meaning the first address of the inaccessible window.
REQ-004 SHALL have parameter OOB_LIMIT, default 'h1_BFFF, meaning the last address (inclusive) of the inaccessible window.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: datapath request valid.
REQ-008 SHALL have port req_addr_i, input, XLEN bits: byte address.
REQ-009 SHALL have port req_size_i, input, 2 bits: access size; 0 byte, 1 half, 2 word, 3 double.
REQ-010 SHALL have port req_wr_i, input, 1 bit: 1 store, 0 load.
REQ-011 SHALL have port req_zero_extnd_i, input, 1 bit: zero-extend load result.
REQ-012 SHALL have port req_wr_data_i, input, XLEN bits: store data, LSB-justified.
REQ-013 SHALL have port req_ready_o, output, 1 bit: request accepted this cycle if valid.
REQ-014 SHALL have port resp_valid_o, output, 1 bit: load result valid.
REQ-015 SHALL have port resp_rd_data_o, output, XLEN bits: aligned and extended load result.
REQ-016 SHALL have port dmem_ready_i, input, 1 bit: memory can accept a request.
REQ-017 SHALL have ports dmem_req_o, dmem_wr_o (outputs, 1 bit each), dmem_addr_o and dmem_wr_data_o (outputs, XLEN bits each) and dmem_mask_o (output, XLEN/8 bits): the memory request.
REQ-018 SHALL have ports dmem_resp_valid_i (input, 1 bit) and dmem_rd_data_i (input, XLEN bits): the memory response, one per issued request, in order.
REQ-019 SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-020 SHALL have ports exc_valid_i (input, 1 bit) and exc_code_i (input, 5 bits): upstream exception.
REQ-021 SHALL have ports exc_valid_o (output, 1 bit) and exc_code_o (output, 5 bits): merged exception.
REQ-022 SHALL have port pending_o, output, $clog2(DEPTH+1) bits: number of in-flight requests.

Function
REQ-023 SHALL drive req_ready_o = dmem_ready_i & (pending < DEPTH); a dequeue in the same cycle SHALL NOT free a slot for that cycle.
REQ-024 SHALL define qualified request q = req_valid_i & req_ready_o & ~flush_i.
REQ-025 SHALL flag oob = q & (OOB_BASE <= addr <= OOB_LIMIT).
REQ-026 SHALL flag misaligned = q & (addr[size-1:0] != 0); size 3 with XLEN=32 SHALL also count as misaligned.
REQ-027 SHALL produce exc_code: oob store 7, oob load 5, misaligned store 6, misaligned load 4; oob takes priority over misaligned.
REQ-028 SHALL drive exc_valid_o = exc_valid_i | oob | misaligned; exc_code_o SHALL be exc_code_i when exc_valid_i is set, otherwise the local code.
REQ-029 SHALL issue (handshake) on q & ~exc_valid_o, driving dmem_req_o=1, dmem_addr_o=req_addr_i and dmem_wr_o=req_wr_i in the same cycle; all dmem_* outputs SHALL be 0 otherwise.
REQ-030 SHALL, for stores, place data on byte lane addr[log2(XLEN/8)-1:0] and set the mask bits covering 2^size bytes; for loads, data and mask SHALL be 0.
REQ-031 SHALL push {addr low bits, size, zero_extnd, wr, killed=0} into a DEPTH-entry in-order queue on each handshake.
REQ-032 SHALL pop the head entry on dmem_resp_valid_i; a response arriving while the queue is empty SHALL be ignored and pending SHALL stay 0.
REQ-033 SHALL assert resp_valid_o combinationally (0-cycle latency) when dmem_resp_valid_i=1, head is a load, head is not killed, ~flush_i and ~exc_valid_i.
REQ-034 SHALL extract 2^size bytes from the head offset and sign-extend them (or zero-extend if zext); size 3 SHALL pass data through unchanged.
REQ-035 SHALL set killed on all valid entries on flush_i; entries pushed in a later cycle SHALL be unaffected; killed responses SHALL be popped silently.
REQ-036 SHALL apply push and pop in the same cycle together, so pending is unchanged; the pointers SHALL wrap modulo DEPTH.

Reset
REQ-037 SHALL, while resetn=0, empty the queue, clear the pointers, killed bits and pending_o, and drive every output to 0 except req_ready_o=dmem_ready_i.
REQ-038 SHALL discard in-flight entries on reset asserted mid-operation; a response after reset SHALL be ignored per REQ-032.

Verification
REQ-039 SHALL cover this scenario (XLEN=64): LB addr 0x1003, mem data 0x00000000_80FF0000 -> dmem mask 0; resp 0xFFFF_FFFF_FFFF_FF80 (LBU: 0x80).
REQ-040 SHALL cover this scenario: SH addr 0x2006, data 0xBEEF -> dmem_wr_data 0xBEEF_0000_0000_0000, mask 0xC0.
REQ-041 SHALL cover this scenario: LW addr 0x1_0004 -> exc_valid_o=1, code 5, no dmem_req_o; SD addr 0x2004 -> code 6.
REQ-042 SHALL cover this scenario (DEPTH=4): 4 loads issued with no responses -> pending_o=4, req_ready_o=0; one response -> pending_o=3, ready=1 next cycle.
REQ-043 SHALL cover this scenario: 2 loads in flight, flush_i pulse, then 1 new load -> first two responses produce no resp_valid_o; third produces resp_valid_o.
REQ-044 SHALL cover this scenario: resetn dropped with 3 pending -> pending_o=0 immediately; a stray dmem_resp_valid_i afterwards -> no resp_valid_o.
